// File: rtl/soc_pad_pkg.sv
// Shared types and constants for the SoC input pad bank.
package soc_pad_pkg;

    localparam int SYNC_STAGES_MIN    = 2;
    localparam int DEFAULT_DEBOUNCE_W = 4;

    typedef struct packed {
        logic rise;
        logic fall;
    } pad_edge_t;

endpackage

// File: rtl/input_pad_filter.sv
// One pad channel: N-flop synchroniser, programmable debounce counter and
// registered rise/fall pulses aligned with the filtered level update.
module input_pad_filter
    import soc_pad_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_MIN,
    parameter int   DEBOUNCE_W  = DEFAULT_DEBOUNCE_W,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pad,
    input  logic                  enable,
    input  logic [DEBOUNCE_W-1:0] debounce_len,
    output logic                  pad_in,
    output pad_edge_t             pad_edge
);

    // A chain shorter than two flops is not a synchroniser, so clamp it.
    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [STAGES-1:0]     sync_q;
    logic [DEBOUNCE_W-1:0] count_q;
    logic                  sync_level;
    logic                  accept;

    assign sync_level = sync_q[STAGES-1];
    assign accept     = enable && (sync_level != pad_in) && (count_q >= debounce_len);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pad};
        end
    end

    // The >= compare lets a shortened debounce length accept immediately and
    // keeps the counter from ever wrapping.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q  <= '0;
            pad_in   <= RESET_VAL;
            pad_edge <= '0;
        end else begin
            pad_edge <= '0;
            if (!enable || (sync_level == pad_in)) begin
                count_q <= '0;
            end else if (accept) begin
                pad_in   <= sync_level;
                count_q  <= '0;
                pad_edge <= '{rise: sync_level, fall: !sync_level};
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrap_input_pad_bank.sv
// Bank of debounced input pads feeding GPIO/interrupt logic.
// Define EDGE_LATCH_EN to add sticky per-channel edge-pending flags.
module wrap_input_pad_bank
    import soc_pad_pkg::*;
#(
    parameter int   NB_CHANNELS = 8,
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE_W  = DEFAULT_DEBOUNCE_W,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NB_CHANNELS-1:0] io_pad,
    input  logic [NB_CHANNELS-1:0] i_en,
    input  logic [DEBOUNCE_W-1:0]  i_debounce_len,
    output logic [NB_CHANNELS-1:0] o_pad_in,
    output logic [NB_CHANNELS-1:0] o_rise,
    output logic [NB_CHANNELS-1:0] o_fall,
    output logic [NB_CHANNELS-1:0] o_edge_pending,
    input  logic [NB_CHANNELS-1:0] i_edge_clr,
    input  logic                   netTie0,
    input  logic                   netTie1,
    input  logic                   vdd_io,
    input  logic                   vdd_co,
    input  logic                   vss
);

    for (genvar c = 0; c < NB_CHANNELS; c++) begin : g_chan
        pad_edge_t ch_edge;

        input_pad_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W),
            .RESET_VAL   (RESET_VAL)
        ) u_filter (
            .clock        (i_clk),
            .reset_n      (i_rst_n),
            .pad          (io_pad[c]),
            .enable       (i_en[c]),
            .debounce_len (i_debounce_len),
            .pad_in       (o_pad_in[c]),
            .pad_edge     (ch_edge)
        );

        assign o_rise[c] = ch_edge.rise;
        assign o_fall[c] = ch_edge.fall;
    end

`ifdef EDGE_LATCH_EN
    logic [NB_CHANNELS-1:0] pending_q;
    logic                   unused_supply;

    // A new edge in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~i_edge_clr) | o_rise | o_fall;
        end
    end

    assign o_edge_pending = pending_q;
    assign unused_supply  = ^{netTie0, netTie1, vdd_io, vdd_co, vss};
`else
    logic unused_supply;

    assign o_edge_pending = '0;
    assign unused_supply  = ^{netTie0, netTie1, vdd_io, vdd_co, vss, i_edge_clr};
`endif

endmodule

// File: tb/tb_wrap_input_pad_bank.sv
// Self-checking bench for wrap_input_pad_bank: directed step table, corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_wrap_input_pad_bank;

    localparam int NB   = 8;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] pad, en, clr;
    logic [3:0]    len;
    logic [NB-1:0] pad_in, rise, fall, pending;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    wrap_input_pad_bank #(
        .NB_CHANNELS (NB),
        .SYNC_STAGES (SYNC),
        .DEBOUNCE_W  (4),
        .RESET_VAL   (1'b0)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .io_pad         (pad),
        .i_en           (en),
        .i_debounce_len (len),
        .o_pad_in       (pad_in),
        .o_rise         (rise),
        .o_fall         (fall),
        .o_edge_pending (pending),
        .i_edge_clr     (clr),
        .netTie0        (1'b0),
        .netTie1        (1'b1),
        .vdd_io         (1'b1),
        .vdd_co         (1'b1),
        .vss            (1'b0)
    );

    // Reference model: the synchroniser is a pure delay looked up in a history
    // of sampled pad words; the filter counts consecutive differing cycles.
    logic [NB-1:0] m_out, m_rise, m_fall, m_pend;
    int            m_cnt [NB];
    logic [NB-1:0] hist [$];

    always @(posedge clk) begin
        logic [NB-1:0] sync_v, nr, nf, no;
        if (!rst_n) begin
            hist.delete();
            m_out  <= '0;
            m_rise <= '0;
            m_fall <= '0;
            m_pend <= '0;
            for (int c = 0; c < NB; c++) m_cnt[c] <= 0;
        end else begin
            sync_v = (hist.size() >= SYNC) ? hist[hist.size()-SYNC] : '0;
            nr = '0;
            nf = '0;
            no = m_out;
            for (int c = 0; c < NB; c++) begin
                if (!en[c] || sync_v[c] == m_out[c]) begin
                    m_cnt[c] <= 0;
                end else if (m_cnt[c] >= int'(len)) begin
                    no[c] = sync_v[c];
                    nr[c] = sync_v[c];
                    nf[c] = !sync_v[c];
                    m_cnt[c] <= 0;
                end else begin
                    m_cnt[c] <= m_cnt[c] + 1;
                end
            end
            m_out  <= no;
            m_rise <= nr;
            m_fall <= nf;
            m_pend <= (m_pend & ~clr) | m_rise | m_fall;
            hist.push_back(pad);
            if (hist.size() > 4) void'(hist.pop_front());
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output();
        logic [NB-1:0] exp_pend;
`ifdef EDGE_LATCH_EN
        exp_pend = m_pend;
`else
        exp_pend = '0;
`endif
        check("model_pad_in", 32'(pad_in), 32'(m_out));
        check("model_rise", 32'(rise), 32'(m_rise));
        check("model_fall", 32'(fall), 32'(m_fall));
        check("model_pending", 32'(pending), 32'(exp_pend));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive a level on one channel and count cycles until the filtered output follows.
    task automatic apply_stimulus(input int ch, input logic level, input int exp_lat, input string name);
        int  n;
        logic pulse;
        pad[ch] = level;
        n = 0;
        pulse = 1'b0;
        while (n < 40) begin
            tick();
            n++;
            if (pad_in[ch] == level) begin
                pulse = level ? rise[ch] : fall[ch];
                break;
            end
        end
        check({name, "_latency"}, 32'(n), 32'(exp_lat));
        check({name, "_pulse"}, 32'(pulse), 32'd1);
    endtask

    typedef struct {
        int         ch;
        logic [3:0] len;
        logic       level;
        int         lat;
    } step_vec_t;

    step_vec_t steps [6];

    initial begin
        int  n;
        logic seen;

        steps[0] = '{ch: 0, len: 4'd4,  level: 1'b1, lat: 7};
        steps[1] = '{ch: 0, len: 4'd4,  level: 1'b0, lat: 7};
        steps[2] = '{ch: 3, len: 4'd0,  level: 1'b1, lat: 3};
        steps[3] = '{ch: 3, len: 4'd0,  level: 1'b0, lat: 3};
        steps[4] = '{ch: 5, len: 4'd15, level: 1'b1, lat: 18};
        steps[5] = '{ch: 6, len: 4'd1,  level: 1'b1, lat: 4};

        rst_n = 1'b0;
        pad   = 8'hFF;
        en    = 8'hFF;
        clr   = 8'h00;
        len   = 4'd3;

        // Reset with all pads high: outputs stay at the reset value.
        idle(2);
        tick();
        check("reset_pad_in", 32'(pad_in), 32'h00);
        check("reset_rise", 32'(rise | fall), 32'h00);

        rst_n = 1'b1;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (pad_in == 8'hFF) break;
        end
        check("release_latency", 32'(n), 32'd6);
        check("release_rise", 32'(rise), 32'hFF);
        tick();
        check("release_rise_one_cycle", 32'(rise), 32'h00);

        pad = 8'h00;
        idle(30);

        foreach (steps[i]) begin
            len = steps[i].len;
            idle(20);
            apply_stimulus(steps[i].ch, steps[i].level, steps[i].lat, $sformatf("step%0d", i));
        end

        // Glitch shorter than the debounce window is swallowed.
        len = 4'd4;
        idle(20);
        pad[1] = 1'b1;
        idle(3);
        pad[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | pad_in[1] | rise[1];
        end
        check("glitch_rejected", 32'(seen), 32'd0);

        // A pulse exactly one debounce window long is accepted, then falls.
        pad[1] = 1'b1;
        idle(5);
        pad[1] = 1'b0;
        seen = 1'b0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            seen = seen | rise[1];
            if (seen && pad_in[1] == 1'b0) break;
        end
        check("pulse_rise_seen", 32'(seen), 32'd1);
        check("pulse_fall_latency", 32'(n), 32'd7);
        check("pulse_fall", 32'(fall[1]), 32'd1);

        // Disabled channel holds its level while the pad toggles.
        en[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pad[2] = ~pad[2];
            tick();
            seen = seen | pad_in[2] | rise[2] | fall[2];
        end
        pad[2] = 1'b1;
        idle(4);
        check("disabled_frozen", 32'(seen | pad_in[2]), 32'd0);
        en[2] = 1'b1;
        n = 0;
        while (n < 30) begin
            tick();
            n++;
            if (pad_in[2]) break;
        end
        check("reenable_latency", 32'(n), 32'd5);

        // Zero debounce length: output follows with a three-cycle delay.
        len = 4'd0;
        idle(20);
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(3, ~pad[3], 3, $sformatf("toggle%0d", k));
            tick();
        end

`ifdef EDGE_LATCH_EN
        pad[4] = 1'b1;
        n = 0;
        while (n < 20 && !rise[4]) begin tick(); n++; end
        tick();
        check("pending_set", 32'(pending[4]), 32'd1);
        clr[4] = 1'b1;
        tick();
        clr[4] = 1'b0;
        check("pending_clear", 32'(pending[4]), 32'd0);
        pad[4] = 1'b0;
        n = 0;
        while (n < 20 && !fall[4]) begin tick(); n++; end
        clr[4] = 1'b1;
        tick();
        clr[4] = 1'b0;
        check("pending_set_wins", 32'(pending[4]), 32'd1);
`endif

        // Reset while a channel is high: level drops with no fall pulse.
        len = 4'd2;
        idle(10);
        apply_stimulus(7, 1'b1, 5, "ch7_high");
        rst_n = 1'b0;
        tick();
        check("midreset_pad_in", 32'(pad_in[7]), 32'd0);
        check("midreset_no_fall", 32'(fall[7]), 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(0, 11) == 0) pad[c] = ~pad[c];
                if ($urandom_range(0, 60) == 0) en[c] = ~en[c];
            end
            if ($urandom_range(0, 40) == 0) len = 4'($urandom_range(0, 6));
            clr   = 8'($urandom);
            rst_n = ($urandom_range(0, 400) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/wrap_input_pad_bank.md
Name: wrap_input_pad_bank

Overview:
- Parametrised successor to the single-pin simulation input pad wrapper.
- Drives NB_CHANNELS pads into the SoC clock domain through three stages per channel:
  - an N-stage synchroniser;
  - a programmable-length debounce filter;
  - single-cycle rise/fall event generation.
- Sits between the pad ring (sim target) and GPIO/interrupt logic, replacing per-pin raw pass-through wrappers.

Parameters:
- NB_CHANNELS, 8, number of input pads.
- SYNC_STAGES, 2, synchroniser flops per channel (min 2).
- DEBOUNCE_W, 4, width of the debounce length and of the per-channel counter.
- RESET_VAL, 1'b0, reset value of synchroniser flops and filtered outputs (same for all channels).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  synchronous active-low reset.
- io_pad  input  NB_CHANNELS  raw asynchronous pad levels.
- i_en  input  NB_CHANNELS  per-channel filter enable.
- i_debounce_len  input  DEBOUNCE_W  stability cycles required before a level change is accepted (shared).
- o_pad_in  output  NB_CHANNELS  synchronised, debounced level.
- o_rise  output  NB_CHANNELS  1-cycle pulse on accepted 0->1.
- o_fall  output  NB_CHANNELS  1-cycle pulse on accepted 1->0.
- o_edge_pending  output  NB_CHANNELS  sticky edge flags (EDGE_LATCH_EN only, else tied 0).
- i_edge_clr  input  NB_CHANNELS  write-one-to-clear for o_edge_pending (ignored without EDGE_LATCH_EN).
- netTie0, netTie1, vdd_io, vdd_co, vss  input  1  leave unconnected in simulation; no functional use.

Behaviour:
- Clock and reset: single clock i_clk. Reset is synchronous, active-low, sampled on the i_clk rising edge.
- Reset values:
  - sync flops = RESET_VAL; o_pad_in = RESET_VAL;
  - counters = 0; o_rise = o_fall = 0; o_edge_pending = 0.
- Synchroniser: io_pad[c] is shifted through SYNC_STAGES flops; sync[c] is the last stage.
- Debounce filter, per channel, evaluated each cycle with i_en[c]=1:
  - sync == o_pad_in: counter <= 0.
  - sync != o_pad_in and counter >= i_debounce_len: o_pad_in <= sync; counter <= 0; the matching o_rise or o_fall is 1 for exactly this update cycle.
  - Otherwise: counter <= counter + 1. The compare uses >=, so the counter never wraps.
  - A glitch returning to the stable level before acceptance resets the counter. No edge is produced.
- Latency: a clean step on io_pad appears on o_pad_in SYNC_STAGES + i_debounce_len + 1 cycles after the first sampling edge. i_debounce_len = 0 gives SYNC_STAGES + 1.
- Edge pulses are registered and aligned with the o_pad_in update. o_rise and o_fall are never both 1 on the same channel.
- i_en[c]=0:
  - o_pad_in[c] holds its value, counter is cleared, no edges are generated;
  - the synchroniser keeps running;
  - on re-enable, the channel restarts filtering from counter 0.
- i_debounce_len changed mid-count: the new value applies from the next cycle. If counter >= new value, the change is accepted at once.
- Reset mid-count: all state returns to reset values. No edge is emitted, even if o_pad_in changes as a result.

Optional Feature:
- Macro: EDGE_LATCH_EN.
- Defined:
  - o_edge_pending[c] sets on o_rise[c] | o_fall[c].
  - It clears when i_edge_clr[c]=1.
  - If set and clear occur in the same cycle, set wins.
- Undefined:
  - o_edge_pending is tied to 0 and i_edge_clr is ignored.
  - No pending registers are instantiated.
  - Port list is unchanged.

Decomposition:
- Package soc_pad_pkg:
  - constants SYNC_STAGES_MIN = 2 and DEFAULT_DEBOUNCE_W = 4;
  - typedef pad_edge_t (struct: rise, fall).
- Sub-module input_pad_filter: one channel's synchroniser, debounce counter and edge generator.
  - Instantiated NB_CHANNELS times in a generate loop.
  - The top holds only the optional pending latches and the supply/tie pass-through.

Test Plan:
1. Reset, RESET_VAL=0, io_pad=0xFF held during reset -> o_pad_in=0x00, o_rise=o_fall=0 while i_rst_n=0; after release with i_debounce_len=3, o_pad_in=0xFF and o_rise=0xFF (one cycle) exactly 2+3+1 cycles later.
2. Ch0 0->1 step, i_debounce_len=4, SYNC_STAGES=2 -> o_pad_in[0]=1 and o_rise[0] pulse at cycle 7 after the step; no pulse on other channels.
3. Ch1 glitch high for 3 cycles, i_debounce_len=4 -> o_pad_in[1] stays 0 and no o_rise; a following 5-cycle high pulse is accepted, then o_fall 7 cycles after it ends.
4. i_en[2]=0 during an io_pad[2] toggle -> o_pad_in[2] frozen, no edges; re-enable with a stable new level -> accepted after i_debounce_len+1 cycles.
5. i_debounce_len=0, io_pad[3] toggling every 4 cycles -> o_pad_in[3] follows with 3-cycle delay; alternating o_rise/o_fall pulses.
6. EDGE_LATCH_EN: o_rise[4] sets o_edge_pending[4]; i_edge_clr[4]=1 one cycle later clears it; a new edge coinciding with i_edge_clr keeps the flag 1.
